// File: rtl/oq_hdr_rx_sm_if.sv
// oq_hdr_rx_sm_if: stream and descriptor bundle for the IOQ module-header receiver.
// The slave modport is the receiver's view. The master modport is the
// upstream/downstream/queue-manager side.
interface oq_hdr_rx_sm_if #(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = DATA_WIDTH / 8,
    parameter int NUM_QUEUES = 8
);
    // Input packet stream
    logic                  in_wr;
    logic [DATA_WIDTH-1:0] in_data;
    logic [CTRL_WIDTH-1:0] in_ctrl;
    logic                  in_rdy;

    // Forwarded packet stream
    logic                  out_wr;
    logic [DATA_WIDTH-1:0] out_data;
    logic [CTRL_WIDTH-1:0] out_ctrl;
    logic                  out_rdy;

    // Descriptor FIFO head
    logic                  desc_vld;
    logic [NUM_QUEUES-1:0] desc_dst_port;
    logic [15:0]           desc_byte_len;
    logic                  desc_err;
    logic                  desc_rd;

    modport slave (
        input  in_wr, in_data, in_ctrl, out_rdy, desc_rd,
        output in_rdy, out_wr, out_data, out_ctrl,
               desc_vld, desc_dst_port, desc_byte_len, desc_err
    );

    modport master (
        output in_wr, in_data, in_ctrl, out_rdy, desc_rd,
        input  in_rdy, out_wr, out_data, out_ctrl,
               desc_vld, desc_dst_port, desc_byte_len, desc_err
    );
endinterface

// File: rtl/oq_hdr_rx_sm.sv
// oq_hdr_rx_sm: validates the leading IOQ module header of each packet.
// Accepted packets are forwarded word-for-word with one cycle of latency,
// and one descriptor per accepted packet goes into a 2-deep FIFO.
// Packets without a usable IOQ header are consumed and discarded.
// Optional feature macro: OQ_LEN_CHECK_EN builds the word counter and the
// word-length check. Without it, desc_err and pkt_len_err are tied to 0.
module oq_hdr_rx_sm #(
    parameter int DATA_WIDTH       = 64,
    parameter int CTRL_WIDTH       = DATA_WIDTH / 8,
    parameter int NUM_QUEUES       = 8,
    parameter logic [CTRL_WIDTH-1:0] IOQ_STAGE_NUM = 8'hff,
    parameter int IOQ_DST_PORT_POS = 48,
    parameter int IOQ_WORD_LEN_POS = 32,
    parameter int IOQ_BYTE_LEN_POS = 0
) (
    input  logic               clk,
    input  logic               reset,
    oq_hdr_rx_sm_if.slave      bus,
    output logic               pkt_accepted,
    output logic               pkt_dropped_bad_hdr,
    output logic               pkt_len_err
);
    localparam logic [3:0] WAIT_HDR    = 4'b0001;
    localparam logic [3:0] MODULE_HDRS = 4'b0010;
    localparam logic [3:0] PKT_BODY    = 4'b0100;
    localparam logic [3:0] DROP_PKT    = 4'b1000;

    logic [3:0]            state_r;
    logic [3:0]            state_nxt_s;
    logic                  acc_s;
    logic                  ctrl_nz_s;
    logic                  eop_s;
    logic                  hdr_ok_s;
    logic                  fwd_s;
    logic                  push_s;
    logic                  drop_s;
    logic                  pop_s;
    logic                  err_s;
    logic                  ctrl_prev_is_0_r;
    logic [NUM_QUEUES-1:0] dst_r;
    logic [15:0]           byte_len_r;

    logic                  out_wr_r;
    logic [DATA_WIDTH-1:0] out_data_r;
    logic [CTRL_WIDTH-1:0] out_ctrl_r;

    logic [NUM_QUEUES-1:0] fifo_dst_r [2];
    logic [15:0]           fifo_len_r [2];
    logic                  fifo_err_r [2];
    logic                  wr_ptr_r;
    logic                  rd_ptr_r;
    logic [1:0]            count_r;

    assign bus.in_rdy = bus.out_rdy && (count_r < 2'd2);
    assign acc_s      = bus.in_wr && bus.in_rdy;
    assign ctrl_nz_s  = (bus.in_ctrl != '0);
    assign eop_s      = ctrl_prev_is_0_r && ctrl_nz_s;
    assign hdr_ok_s   = (bus.in_ctrl == IOQ_STAGE_NUM) &&
                        (bus.in_data[IOQ_DST_PORT_POS +: NUM_QUEUES] != '0);
    assign pop_s      = bus.desc_rd && (count_r != 2'd0);

    // Next-state decode plus the forward, push and drop strobes for the accepted word
    always_comb begin
        state_nxt_s = state_r;
        fwd_s       = 1'b0;
        push_s      = 1'b0;
        drop_s      = 1'b0;
        if (acc_s) begin
            case (state_r)
                WAIT_HDR: begin
                    if (hdr_ok_s) begin
                        fwd_s       = 1'b1;
                        state_nxt_s = MODULE_HDRS;
                    end else begin
                        drop_s      = 1'b1;
                        state_nxt_s = DROP_PKT;
                    end
                end
                MODULE_HDRS: begin
                    fwd_s = 1'b1;
                    if (!ctrl_nz_s) begin
                        state_nxt_s = PKT_BODY;
                    end else begin
                        state_nxt_s = MODULE_HDRS;
                    end
                end
                PKT_BODY: begin
                    fwd_s = 1'b1;
                    if (eop_s) begin
                        push_s      = 1'b1;
                        state_nxt_s = WAIT_HDR;
                    end else begin
                        state_nxt_s = PKT_BODY;
                    end
                end
                DROP_PKT: begin
                    if (eop_s) begin
                        state_nxt_s = WAIT_HDR;
                    end else begin
                        state_nxt_s = DROP_PKT;
                    end
                end
                default: begin
                    state_nxt_s = WAIT_HDR;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // State register, EOP tracking and latching of the header fields
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r          <= WAIT_HDR;
            ctrl_prev_is_0_r <= 1'b0;
            dst_r            <= '0;
            byte_len_r       <= 16'd0;
        end else begin
            state_r <= state_nxt_s;
            if (acc_s) begin
                ctrl_prev_is_0_r <= !ctrl_nz_s;
            end
            if (acc_s && (state_r == WAIT_HDR) && hdr_ok_s) begin
                dst_r      <= bus.in_data[IOQ_DST_PORT_POS +: NUM_QUEUES];
                byte_len_r <= bus.in_data[IOQ_BYTE_LEN_POS +: 16];
            end
        end
    end

`ifdef OQ_LEN_CHECK_EN
    logic [15:0] word_len_r;
    logic [15:0] wcnt_r;

    // Count body words so the total, including the EOP word, can be checked against the header
    always_ff @(posedge clk) begin
        if (reset) begin
            word_len_r <= 16'd0;
            wcnt_r     <= 16'd0;
        end else if (acc_s) begin
            if ((state_r == WAIT_HDR) && hdr_ok_s) begin
                word_len_r <= bus.in_data[IOQ_WORD_LEN_POS +: 16];
                wcnt_r     <= 16'd0;
            end else if ((state_r == MODULE_HDRS) && !ctrl_nz_s) begin
                wcnt_r <= 16'd1;
            end else if (state_r == PKT_BODY) begin
                wcnt_r <= wcnt_r + 16'd1;
            end
        end
    end

    // Flag a length mismatch on the EOP word that pushes the descriptor
    always_comb begin
        err_s = 1'b0;
        if (push_s) begin
            err_s = ((wcnt_r + 16'd1) != word_len_r);
        end else begin
            err_s = 1'b0;
        end
    end
`else
    assign err_s = 1'b0;
`endif

    assign pkt_accepted        = push_s;
    assign pkt_dropped_bad_hdr = drop_s;
    assign pkt_len_err         = err_s;

    // Forwarded stream: one-cycle registered copy of each forwarded word
    always_ff @(posedge clk) begin
        if (reset) begin
            out_wr_r   <= 1'b0;
            out_data_r <= '0;
            out_ctrl_r <= {{(CTRL_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            out_wr_r <= fwd_s;
            if (fwd_s) begin
                out_data_r <= bus.in_data;
                out_ctrl_r <= bus.in_ctrl;
            end
        end
    end

    assign bus.out_wr   = out_wr_r;
    assign bus.out_data = out_data_r;
    assign bus.out_ctrl = out_ctrl_r;

    // Two-entry descriptor FIFO. A push and a pop in the same cycle leave the count unchanged.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            count_r  <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                fifo_dst_r[i] <= '0;
                fifo_len_r[i] <= 16'd0;
                fifo_err_r[i] <= 1'b0;
            end
        end else begin
            if (push_s) begin
                fifo_dst_r[wr_ptr_r] <= dst_r;
                fifo_len_r[wr_ptr_r] <= byte_len_r;
                fifo_err_r[wr_ptr_r] <= err_s;
                wr_ptr_r             <= ~wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    assign bus.desc_vld      = (count_r != 2'd0);
    assign bus.desc_dst_port = fifo_dst_r[rd_ptr_r];
    assign bus.desc_byte_len = fifo_len_r[rd_ptr_r];
    assign bus.desc_err      = fifo_err_r[rd_ptr_r];
endmodule

// File: tb/tb_oq_hdr_rx_sm.sv
// tb_oq_hdr_rx_sm: randomized packet-level reference model for oq_hdr_rx_sm.
// Each generated word carries its expected fate: forwarded or not, drop
// pulse, accept pulse, and descriptor contents. The bench compares every
// cycle against that model. OQ_LEN_CHECK_EN selects the expected error behaviour.
module tb_oq_hdr_rx_sm;
    logic clk = 1'b0;
    logic reset;
    logic pkt_accepted, pkt_dropped_bad_hdr, pkt_len_err;

    always #5 clk = ~clk;

    oq_hdr_rx_sm_if #(.DATA_WIDTH(64), .CTRL_WIDTH(8), .NUM_QUEUES(8)) bus ();

    oq_hdr_rx_sm dut (
        .clk                 (clk),
        .reset               (reset),
        .bus                 (bus),
        .pkt_accepted        (pkt_accepted),
        .pkt_dropped_bad_hdr (pkt_dropped_bad_hdr),
        .pkt_len_err         (pkt_len_err)
    );

    typedef struct {
        logic [63:0] d;
        logic [7:0]  c;
        bit          fwd;
        bit          bad_first;
        bit          last_good;
        bit          err;
        logic [7:0]  dst;
        logic [15:0] blen;
    } word_t;

    typedef struct {
        logic [7:0]  dst;
        logic [15:0] blen;
        bit          err;
    } desc_t;

    word_t       wq[$];
    desc_t       dq[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    bit          exp_ow;
    logic [63:0] exp_od;
    logic [7:0]  exp_oc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // kind 0 = good IOQ packet, 1 = first word ctrl 0, 2 = IOQ header with dst 0, 3 = non-IOQ header
    task automatic build_pkt(input int kind, input logic [7:0] dst, input int nextra,
                             input int nbody, input logic [15:0] wl, input logic [15:0] bl);
        word_t w;
        bit    good;
        bit    err;
        good = (kind == 0);
        err  = 1'b0;
`ifdef OQ_LEN_CHECK_EN
        err = good && (wl != 16'(nbody + 1));
`endif
        w.fwd = good; w.bad_first = !good; w.last_good = 1'b0; w.err = 1'b0;
        w.dst = dst; w.blen = bl;
        w.d = {8'($urandom), (kind == 2) ? 8'h00 : dst, wl, 16'($urandom), bl};
        if (kind == 1)      w.c = 8'h00;
        else if (kind == 3) w.c = 8'($urandom_range(1, 254));
        else                w.c = 8'hff;
        wq.push_back(w);
        w.bad_first = 1'b0;
        if (kind != 1) begin
            for (int i = 0; i < nextra; i++) begin
                w.d = {$urandom, $urandom};
                w.c = 8'($urandom_range(1, 254));
                wq.push_back(w);
            end
        end
        for (int i = (kind == 1) ? 1 : 0; i < nbody; i++) begin
            w.d = {$urandom, $urandom};
            w.c = 8'h00;
            wq.push_back(w);
        end
        w.d = {$urandom, $urandom};
        w.c = 8'($urandom_range(1, 127));
        w.last_good = good;
        w.err = err;
        wq.push_back(w);
    endtask

    task automatic rand_pkt();
        int          kind;
        int          nb;
        logic [15:0] wl;
        kind = ($urandom_range(0, 9) < 6) ? 0 : int'($urandom_range(1, 3));
        nb   = int'($urandom_range(1, 4));
        wl   = ($urandom_range(0, 9) < 7) ? 16'(nb + 1) : 16'($urandom_range(0, 15));
        build_pkt(kind, 8'(1 << $urandom_range(0, 7)), int'($urandom_range(0, 2)), nb, wl,
                  16'($urandom));
    endtask

    // One clock: check registered outputs, drive inputs, check combinational outputs, advance model
    task automatic step(input int p_wr, input int p_rdy, input int p_rd);
        word_t w;
        desc_t dsc;
        bit    rdy, rd, exp_rdy, do_wr;
        @(negedge clk);
        chk("out_wr", bus.out_wr, exp_ow);
        if (exp_ow) begin
            chk("out_data", bus.out_data, exp_od);
            chk("out_ctrl", bus.out_ctrl, exp_oc);
        end
        chk("desc_vld", bus.desc_vld, dq.size() != 0);
        if (dq.size() != 0) begin
            chk("desc_dst", bus.desc_dst_port, dq[0].dst);
            chk("desc_len", bus.desc_byte_len, dq[0].blen);
            chk("desc_err", bus.desc_err, dq[0].err);
        end
        rdy     = (int'($urandom_range(0, 99)) < p_rdy);
        rd      = (int'($urandom_range(0, 99)) < p_rd);
        exp_rdy = rdy && (dq.size() < 2);
        do_wr   = exp_rdy && (wq.size() > 0) && (int'($urandom_range(0, 99)) < p_wr);
        bus.out_rdy = rdy;
        bus.desc_rd = rd;
        if (do_wr) begin
            w = wq[0];
            bus.in_wr = 1'b1; bus.in_data = w.d; bus.in_ctrl = w.c;
        end else begin
            w.last_good = 1'b0; w.bad_first = 1'b0; w.err = 1'b0; w.fwd = 1'b0;
            bus.in_wr = 1'b0; bus.in_data = {$urandom, $urandom}; bus.in_ctrl = 8'($urandom);
        end
        #1;
        chk("in_rdy", bus.in_rdy, exp_rdy);
        chk("pkt_accepted", pkt_accepted, do_wr && w.last_good);
        chk("pkt_dropped", pkt_dropped_bad_hdr, do_wr && w.bad_first);
        chk("pkt_len_err", pkt_len_err, do_wr && w.last_good && w.err);
        @(posedge clk);
        if (rd && (dq.size() > 0)) void'(dq.pop_front());
        if (do_wr) begin
            void'(wq.pop_front());
            exp_ow = w.fwd; exp_od = w.d; exp_oc = w.c;
            if (w.last_good) begin
                dsc.dst = w.dst; dsc.blen = w.blen; dsc.err = w.err;
                dq.push_back(dsc);
            end
        end else begin
            exp_ow = 1'b0;
        end
    endtask

    task automatic drain(input int p_wr, input int p_rdy, input int p_rd);
        int guard = 0;
        while (((wq.size() > 0) || (dq.size() > 0) || exp_ow) && (guard < 20000)) begin
            step(p_wr, p_rdy, p_rd);
            guard++;
        end
        if (guard >= 20000) chk("drain_timeout", 64'd1, 64'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int guard;
        reset = 1'b1;
        bus.in_wr = 1'b0; bus.in_data = 64'd0; bus.in_ctrl = 8'd0;
        bus.out_rdy = 1'b1; bus.desc_rd = 1'b0;
        exp_ow = 1'b0; exp_od = 64'd0; exp_oc = 8'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_wr", bus.out_wr, 64'd0);
        chk("rst_out_data", bus.out_data, 64'd0);
        chk("rst_out_ctrl", bus.out_ctrl, 64'd1);
        chk("rst_desc_vld", bus.desc_vld, 64'd0);
        chk("rst_in_rdy", bus.in_rdy, 64'd1);
        reset = 1'b0;

        // Directed cases: nominal, ctrl-0 first word, dst 0, length mismatch
        build_pkt(0, 8'h04, 1, 2, 16'd3, 16'd20);
        build_pkt(1, 8'h00, 0, 3, 16'd0, 16'd0);
        build_pkt(0, 8'h01, 0, 1, 16'd2, 16'd64);
        build_pkt(2, 8'h00, 1, 2, 16'd3, 16'd20);
        build_pkt(0, 8'h10, 0, 2, 16'd4, 16'd24);
        build_pkt(3, 8'h02, 2, 2, 16'd3, 16'd5);
        drain(100, 100, 100);

        // Back-to-back packets with no descriptor reads, so the FIFO fills and stalls input
        build_pkt(0, 8'h01, 0, 2, 16'd3, 16'd11);
        build_pkt(0, 8'h02, 1, 1, 16'd2, 16'd12);
        build_pkt(0, 8'h80, 0, 3, 16'd4, 16'd13);
        repeat (30) step(100, 100, 0);
        step(100, 100, 100);
        repeat (10) step(100, 100, 0);
        drain(100, 100, 60);

        // Randomized traffic with random back-pressure and descriptor reads
        for (int i = 0; i < 200; i++) rand_pkt();
        drain(70, 85, 40);

        // Reset in the middle of a packet body
        build_pkt(0, 8'h02, 1, 3, 16'd4, 16'd30);
        guard = 0;
        while ((wq.size() > 2) && (guard < 1000)) begin
            step(100, 100, 100);
            guard++;
        end
        if (guard >= 1000) chk("midrst_timeout", 64'd1, 64'd0);
        @(negedge clk);
        reset = 1'b1; bus.in_wr = 1'b0; bus.desc_rd = 1'b0;
        @(negedge clk);
        chk("midrst_out_wr", bus.out_wr, 64'd0);
        chk("midrst_out_ctrl", bus.out_ctrl, 64'd1);
        chk("midrst_desc_vld", bus.desc_vld, 64'd0);
        reset = 1'b0;
        dq.delete();
        exp_ow = 1'b0;
        foreach (wq[i]) begin
            wq[i].fwd = 1'b0; wq[i].last_good = 1'b0; wq[i].err = 1'b0; wq[i].bad_first = 1'b0;
        end
        if (wq.size() > 0) wq[0].bad_first = 1'b1;
        build_pkt(0, 8'h08, 0, 2, 16'd3, 16'd40);
        drain(100, 100, 100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
